// File: rtl/chess_pkg.sv
// Shared definitions for the chessboard layout scanner: piece codes,
// square-byte field positions and the scanner state encoding.
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        ROOK   = 3'd3,
        BISHOP = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } chessman_t;

    // Bit positions inside one square byte; bit 7 is reserved but still
    // participates in change detection.
    localparam int PIECE_LSB = 0;
    localparam int PIECE_MSB = 2;
    localparam int COLOUR    = 3;
    localparam int CURSOR    = 4;
    localparam int LOCK_SRC  = 5;
    localparam int LOCK_CUR  = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SCAN    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } scanState_t;

endpackage

// File: rtl/chess_layout_scanner_if.sv
// Square-descriptor stream from the layout scanner to the board renderer.
interface chess_layout_scanner_if;

    // Handshake: a descriptor transfers on a rising clock edge where both
    // SquareValid and SquareReady are 1. Once SquareValid rises, it and every
    // descriptor field hold steady until that transfer; SquareValid never
    // depends combinationally on SquareReady.
    logic       SquareValid;
    logic       SquareReady;
    logic [5:0] SquareIdx;
    logic [2:0] SquareX;
    logic [2:0] SquareY;
    logic [2:0] Chessman;
    logic       IsWhite;
    logic       Cursor;
    logic       LockedSrc;
    logic       LockCursor;
    logic       LightSquare;

    modport master (
        output SquareValid, SquareIdx, SquareX, SquareY, Chessman,
               IsWhite, Cursor, LockedSrc, LockCursor, LightSquare,
        input  SquareReady
    );

    modport slave (
        input  SquareValid, SquareIdx, SquareX, SquareY, Chessman,
               IsWhite, Cursor, LockedSrc, LockCursor, LightSquare,
        output SquareReady
    );

endinterface

// File: rtl/chess_square_decode.sv
// Pure combinational decode of one square byte and its board index into
// the descriptor fields the renderer consumes.
module chess_square_decode
    import chess_pkg::*;
(
    input  logic [7:0] squareByte,
    input  logic [5:0] squareIdx,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [2:0] chessman,
    output logic       isWhite,
    output logic       cursor,
    output logic       lockedSrc,
    output logic       lockCursor,
    output logic       lightSquare
);

    logic unusedBit7;

    assign x          = squareIdx[2:0];
    assign y          = squareIdx[5:3];
    assign chessman   = squareByte[PIECE_MSB:PIECE_LSB];
    assign isWhite    = squareByte[COLOUR];
    assign cursor     = squareByte[CURSOR];
    assign lockedSrc  = squareByte[LOCK_SRC];
    assign lockCursor = squareByte[LOCK_CUR];
    // (x+y) is even exactly when the low bits of x and y agree.
    assign lightSquare = ~(squareIdx[0] ^ squareIdx[3]);
    assign unusedBit7  = squareByte[7];

endmodule

// File: rtl/chess_layout_scanner.sv
// Snapshots the flat Layout bus on request and streams per-square
// descriptors, either for every square or only for squares that changed.
module chess_layout_scanner
    import chess_pkg::*;
#(
    parameter int CHESS_SQUARES = 64,
    parameter int SQUARE_WIDTH  = 8,
    parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetApp,
    input  logic [MATRIX_WIDTH-1:0] Layout,
    input  logic                    FrameStart,
    input  logic                    FullRefresh,
    chess_layout_scanner_if.master  squareBus,
    output logic                    Busy,
    output logic                    ScanDone,
    output logic [6:0]              ChangedCount,
    output scanState_t              ScanState
);

    scanState_t state;
    scanState_t nextState;

    logic [SQUARE_WIDTH-1:0] snapshot [CHESS_SQUARES];
    logic [SQUARE_WIDTH-1:0] previous [CHESS_SQUARES];

    logic [5:0] idx;
    logic [6:0] count;
    logic       fullMode;
    logic       prevValid;

    logic [SQUARE_WIDTH-1:0] curByte;
    logic                    lastIdx;
    logic                    emitHit;
    logic                    emitAccept;

    logic [2:0] decX;
    logic [2:0] decY;
    logic [2:0] decChessman;
    logic       decWhite;
    logic       decCursor;
    logic       decLockSrc;
    logic       decLockCur;
    logic       decLight;

    logic       sqValid;
    logic [5:0] sqIdx;
    logic [2:0] sqX;
    logic [2:0] sqY;
    logic [2:0] sqChessman;
    logic       sqWhite;
    logic       sqCursor;
    logic       sqLockSrc;
    logic       sqLockCur;
    logic       sqLight;

    assign curByte    = snapshot[idx];
    assign lastIdx    = (idx == 6'd63);
    assign emitHit    = fullMode || (curByte != previous[idx]);
    assign emitAccept = (state == ST_EMIT) && squareBus.SquareReady;

    chess_square_decode u_decode (
        .squareByte  (curByte),
        .squareIdx   (idx),
        .x           (decX),
        .y           (decY),
        .chessman    (decChessman),
        .isWhite     (decWhite),
        .cursor      (decCursor),
        .lockedSrc   (decLockSrc),
        .lockCursor  (decLockCur),
        .lightSquare (decLight)
    );

    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) state <= ST_IDLE;
        else           state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:    if (FrameStart) nextState = ST_CAPTURE;
            ST_CAPTURE: nextState = ST_SCAN;
            ST_SCAN: begin
                if (emitHit)      nextState = ST_EMIT;
                else if (lastIdx) nextState = ST_DONE;
            end
            ST_EMIT: begin
                if (squareBus.SquareReady) nextState = lastIdx ? ST_DONE : ST_SCAN;
            end
            ST_DONE:    nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase
    end

    // Previous only ever holds bytes the renderer has actually accepted.
    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            for (int i = 0; i < CHESS_SQUARES; i++) begin
                snapshot[i] <= '0;
                previous[i] <= '0;
            end
        end else begin
            if (state == ST_CAPTURE) begin
                for (int i = 0; i < CHESS_SQUARES; i++) begin
                    snapshot[i] <= Layout[i*SQUARE_WIDTH +: SQUARE_WIDTH];
                end
            end
            if (emitAccept) previous[idx] <= snapshot[idx];
        end
    end

    always_ff @(posedge clock or negedge resetApp) begin
        if (!resetApp) begin
            idx          <= '0;
            count        <= '0;
            fullMode     <= 1'b0;
            prevValid    <= 1'b0;
            ChangedCount <= '0;
            sqValid      <= 1'b0;
            sqIdx        <= '0;
            sqX          <= '0;
            sqY          <= '0;
            sqChessman   <= '0;
            sqWhite      <= 1'b0;
            sqCursor     <= 1'b0;
            sqLockSrc    <= 1'b0;
            sqLockCur    <= 1'b0;
            sqLight      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (FrameStart) fullMode <= FullRefresh || !prevValid;
                end
                ST_CAPTURE: begin
                    idx   <= '0;
                    count <= '0;
                end
                ST_SCAN: begin
                    if (emitHit) begin
                        sqValid    <= 1'b1;
                        sqIdx      <= idx;
                        sqX        <= decX;
                        sqY        <= decY;
                        sqChessman <= decChessman;
                        sqWhite    <= decWhite;
                        sqCursor   <= decCursor;
                        sqLockSrc  <= decLockSrc;
                        sqLockCur  <= decLockCur;
                        sqLight    <= decLight;
                    end else if (!lastIdx) begin
                        idx <= idx + 6'd1;
                    end
                end
                ST_EMIT: begin
                    if (squareBus.SquareReady) begin
                        sqValid <= 1'b0;
                        count   <= count + 7'd1;
                        if (!lastIdx) idx <= idx + 6'd1;
                    end
                end
                ST_DONE: begin
                    ChangedCount <= count;
                    prevValid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign squareBus.SquareValid = sqValid;
    assign squareBus.SquareIdx   = sqIdx;
    assign squareBus.SquareX     = sqX;
    assign squareBus.SquareY     = sqY;
    assign squareBus.Chessman    = sqChessman;
    assign squareBus.IsWhite     = sqWhite;
    assign squareBus.Cursor      = sqCursor;
    assign squareBus.LockedSrc   = sqLockSrc;
    assign squareBus.LockCursor  = sqLockCur;
    assign squareBus.LightSquare = sqLight;

    assign Busy      = (state != ST_IDLE);
    assign ScanDone  = (state == ST_DONE);
    assign ScanState = state;

endmodule

// File: tb/tb_chess_layout_scanner.sv
// Directed bench for chess_layout_scanner: full, delta, stalled, aborted
// and overlapping scan requests against hand-computed descriptors.
module tb_chess_layout_scanner;
    import chess_pkg::*;

    logic         clock = 1'b0;
    logic         resetApp;
    logic [511:0] Layout;
    logic         FrameStart;
    logic         FullRefresh;
    logic         Busy;
    logic         ScanDone;
    logic [6:0]   ChangedCount;
    scanState_t   ScanState;

    chess_layout_scanner_if bus ();

    chess_layout_scanner dut (
        .clock        (clock),
        .resetApp     (resetApp),
        .Layout       (Layout),
        .FrameStart   (FrameStart),
        .FullRefresh  (FullRefresh),
        .squareBus    (bus),
        .Busy         (Busy),
        .ScanDone     (ScanDone),
        .ChangedCount (ChangedCount),
        .ScanState    (ScanState)
    );

    always #5 clock = ~clock;

    int testCount = 0;
    int failCount = 0;

    logic [19:0] expQ [$];
    logic [7:0]  prevModel [64];
    logic [19:0] seenDesc [64];
    bit          modelPrevValid = 1'b0;
    int          emittedInScan = 0;
    int          doneCount = 0;
    int          doneBefore = 0;

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [19:0] descLit(input int i, input int x, input int y, input int piece,
                                            input int white, input int cur, input int lsrc,
                                            input int lcur, input int light);
        return {i[5:0], x[2:0], y[2:0], piece[2:0], white[0], cur[0], lsrc[0], lcur[0], light[0]};
    endfunction

    function automatic logic [19:0] modelDesc(input int i, input logic [7:0] b);
        int light;
        light = (((i % 8) + (i / 8)) % 2 == 0) ? 1 : 0;
        return descLit(i, i % 8, i / 8, int'(b[2:0]), int'(b[3]), int'(b[4]),
                       int'(b[5]), int'(b[6]), light);
    endfunction

    function automatic logic [19:0] busDesc();
        return {bus.SquareIdx, bus.SquareX, bus.SquareY, bus.Chessman, bus.IsWhite,
                bus.Cursor, bus.LockedSrc, bus.LockCursor, bus.LightSquare};
    endfunction

    // Scoreboard: every accepted descriptor must match the queue head.
    always @(negedge clock) begin
        if (resetApp && bus.SquareValid && bus.SquareReady) begin
            if (expQ.size() == 0) begin
                checkValue("desc_pending", expQ.size(), 1);
            end else begin
                logic [19:0] e;
                e = expQ.pop_front();
                checkValue($sformatf("desc_%0d", bus.SquareIdx), busDesc(), e);
            end
            seenDesc[bus.SquareIdx] = busDesc();
            emittedInScan++;
        end
        if (resetApp && ScanDone) doneCount++;
    end

    task automatic setSquare(input int i, input logic [7:0] v);
        Layout[i*8 +: 8] = v;
    endtask

    task automatic startScan(input bit full);
        bit f;
        f = full || !modelPrevValid;
        expQ.delete();
        emittedInScan = 0;
        doneBefore = doneCount;
        for (int i = 0; i < 64; i++) begin
            if (f || (Layout[i*8 +: 8] != prevModel[i])) begin
                expQ.push_back(modelDesc(i, Layout[i*8 +: 8]));
                prevModel[i] = Layout[i*8 +: 8];
            end
        end
        modelPrevValid = 1'b1;
        @(posedge clock);
        #1;
        FullRefresh = full;
        FrameStart = 1'b1;
    endtask

    task automatic finishScan(input int expCount, output int cycles, output int firstValid);
        bit sawDone;
        sawDone = 1'b0;
        cycles = -1;
        firstValid = -1;
        for (int k = 0; k < 1000 && !sawDone; k++) begin
            @(negedge clock);
            if (bus.SquareValid && firstValid < 0) firstValid = k;
            if (ScanDone) begin
                sawDone = 1'b1;
                cycles = k;
            end else begin
                @(posedge clock);
                #1;
                FrameStart = 1'b0;
            end
        end
        checkValue("scan_done_seen", sawDone, 1);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkValue("changed_count", ChangedCount, expCount);
        checkValue("emitted_count", emittedInScan, expCount);
        checkValue("queue_drained", expQ.size(), 0);
        checkValue("done_pulses", doneCount, doneBefore + 1);
        checkValue("busy_after_done", Busy, 0);
        checkValue("state_after_done", int'(ScanState), int'(ST_IDLE));
    endtask

    task automatic runScan(input bit full, input int expCount, input int expCycles, input int expFirst);
        int cycles;
        int firstValid;
        startScan(full);
        finishScan(expCount, cycles, firstValid);
        if (expCycles >= 0) checkValue("scan_cycles", cycles, expCycles);
        if (expFirst != -2) checkValue("first_valid_cycle", firstValid, expFirst);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [19:0] held;
        int cyc;
        int fv;

        resetApp = 1'b0;
        Layout = '0;
        FrameStart = 1'b0;
        FullRefresh = 1'b0;
        bus.SquareReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            prevModel[i] = 8'h00;
            seenDesc[i] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkValue("rst_valid", bus.SquareValid, 0);
        checkValue("rst_busy", Busy, 0);
        checkValue("rst_done", ScanDone, 0);
        checkValue("rst_count", ChangedCount, 0);
        checkValue("rst_state", int'(ScanState), int'(ST_IDLE));
        @(posedge clock);
        #1;
        resetApp = 1'b1;

        // First scan after reset is forced full even with FullRefresh=0.
        setSquare(0, 8'h03);
        setSquare(63, 8'h0E);
        runScan(1'b0, 64, 130, 3);
        checkValue("sq0_desc", seenDesc[0], descLit(0, 0, 0, 3, 0, 0, 0, 0, 1));
        checkValue("sq63_desc", seenDesc[63], descLit(63, 7, 7, 6, 1, 0, 0, 0, 1));

        // Nothing changed: 64 SCAN cycles and no descriptors.
        runScan(1'b0, 0, 66, -1);

        // Single change.
        setSquare(19, 8'h1B);
        runScan(1'b0, 1, 67, 22);
        checkValue("sq19_desc", seenDesc[19], descLit(19, 3, 2, 3, 1, 1, 0, 0, 0));

        // Backpressure with Layout altered after capture.
        setSquare(5, 8'h25);
        setSquare(40, 8'h41);
        bus.SquareReady = 1'b0;
        startScan(1'b0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clock);
            #1;
            FrameStart = 1'b0;
            @(negedge clock);
            if (bus.SquareValid) found = 1'b1;
        end
        checkValue("stall_valid_seen", found, 1);
        held = busDesc();
        checkValue("stall_first_desc", held, descLit(5, 5, 0, 5, 0, 0, 1, 0, 0));
        for (int s = 0; s < 5; s++) begin
            @(posedge clock);
            #1;
            if (s == 0) begin
                setSquare(5, 8'h11);
                setSquare(40, 8'h7F);
            end
            @(negedge clock);
            checkValue($sformatf("stall_valid_%0d", s), bus.SquareValid, 1);
            checkValue($sformatf("stall_hold_%0d", s), busDesc(), held);
        end
        @(posedge clock);
        #1;
        bus.SquareReady = 1'b1;
        finishScan(2, cyc, fv);
        checkValue("sq40_captured", seenDesc[40], descLit(40, 0, 5, 1, 0, 0, 0, 1, 0));

        // The mid-scan edits surface on the following delta scan.
        runScan(1'b0, 2, -1, -2);
        checkValue("sq5_next", seenDesc[5], descLit(5, 5, 0, 1, 0, 1, 0, 0, 0));
        checkValue("sq40_next", seenDesc[40], descLit(40, 0, 5, 7, 1, 1, 1, 1, 0));

        // A second request while busy is dropped, not queued.
        startScan(1'b0);
        @(posedge clock);
        #1;
        FrameStart = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        FrameStart = 1'b1;
        @(negedge clock);
        checkValue("busy_during_scan", Busy, 1);
        @(posedge clock);
        #1;
        FrameStart = 1'b0;
        finishScan(0, cyc, fv);
        repeat (80) @(negedge clock);
        checkValue("no_queued_scan", doneCount, doneBefore + 1);
        checkValue("idle_after_busy_req", Busy, 0);

        // Reset in the middle of a full scan at descriptor 10.
        startScan(1'b1);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clock);
            #1;
            FrameStart = 1'b0;
            @(negedge clock);
            if (bus.SquareValid && bus.SquareIdx == 6'd10) found = 1'b1;
        end
        checkValue("reached_desc10", found, 1);
        doneBefore = doneCount;
        resetApp = 1'b0;
        #1;
        checkValue("abort_valid", bus.SquareValid, 0);
        checkValue("abort_idx", bus.SquareIdx, 0);
        checkValue("abort_chessman", bus.Chessman, 0);
        checkValue("abort_busy", Busy, 0);
        checkValue("abort_state", int'(ScanState), int'(ST_IDLE));
        expQ.delete();
        modelPrevValid = 1'b0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        resetApp = 1'b1;
        repeat (100) @(negedge clock);
        checkValue("abort_no_done", doneCount, doneBefore);
        checkValue("abort_idle", Busy, 0);

        // With PrevValid cleared, a delta request still emits everything.
        runScan(1'b0, 64, 130, 3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
